fifo_ram32x8_controller: RTL and testbench

Sequencing controller that turns the structural 32x8 RAM (four 8-row banks, 32 one-hot word lines in total, shared data-in/data-out buses, single Write_Enable) into a synchronous FIFO. It arbitrates push and pop requests onto the RAM's single access port. It also generates registered one-hot row selects and write strobes, tracks read/write pointers and occupancy, and returns read data with a valid pulse. It sits between the FIFO's client logic and the RAM32x8 datapath.

---
 rtl/fifo_ram32x8_controller_if.sv | 34 +++
 rtl/fifo_ram32x8_controller.sv | 129 ++++++++++++
 tb/tb_fifo_ram32x8_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ram32x8_controller_if.sv
// Client/RAM-facing bundle of the 32x8 RAM FIFO controller.
// The master side (client logic plus RAM read bus) drives requests; the slave side is the controller.
interface fifo_ram32x8_controller_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
);
  logic                  push;
  logic [WIDTH-1:0]      push_data;
  logic                  push_ready;
  logic                  pop;
  logic                  pop_ready;
  logic [WIDTH-1:0]      pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic [DEPTH-1:0]      row_select;
  logic                  write_enable;
  logic [WIDTH-1:0]      ram_input;
  logic [WIDTH-1:0]      ram_output;

  modport master (
    output push, push_data, pop, ram_output,
    input  push_ready, pop_ready, pop_data, pop_valid, full, empty, count,
           row_select, write_enable, ram_input
  );

  modport slave (
    input  push, push_data, pop, ram_output,
    output push_ready, pop_ready, pop_data, pop_valid, full, empty, count,
           row_select, write_enable, ram_input
  );
endinterface

// File: rtl/fifo_ram32x8_controller.sv
// Turns the single-port 32x8 latch RAM into a synchronous FIFO: round-robin push/pop
// arbitration, registered one-hot row selects and write strobe, pointers and occupancy.
module fifo_ram32x8_controller #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input logic                          i_clock,
  input logic                          i_reset,
  fifo_ram32x8_controller_if.slave     io_bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_last_write;
  logic [DEPTH-1:0]      r_row_select;
  logic                  r_write_enable;
  logic [WIDTH-1:0]      r_ram_input;
  logic [WIDTH-1:0]      r_pop_data;
  logic                  r_pop_valid;

  logic w_full, w_empty, w_idle;
  logic w_push_legal, w_pop_legal;
  logic w_push_ready, w_pop_ready;
  logic w_push_go, w_pop_go;

  function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_WIDTH-1:0] ptr);
    logic [DEPTH-1:0] sel;
    sel      = '0;
    sel[ptr] = 1'b1;
    return sel;
  endfunction

  assign w_full       = (r_count == FULL_COUNT);
  assign w_empty      = (r_count == '0);
  assign w_idle       = (r_state == S_IDLE);
  assign w_push_legal = io_bus.push && !w_full;
  assign w_pop_legal  = io_bus.pop && !w_empty;

  // On a tie the side that was not served last gets the port.
  assign w_push_ready = w_idle && !w_full  && !(w_pop_legal  &&  r_last_write);
  assign w_pop_ready  = w_idle && !w_empty && !(w_push_legal && !r_last_write);
  assign w_push_go    = io_bus.push && w_push_ready;
  assign w_pop_go     = io_bus.pop  && w_pop_ready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_push_go)     w_next_state = S_WRITE;
        else if (w_pop_go) w_next_state = S_READ;
      end
      S_WRITE: w_next_state = S_IDLE;
      S_READ:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Select and strobe come straight from flops so the latch cells never see decode glitches.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_last_write   <= 1'b0;
      r_row_select   <= '0;
      r_write_enable <= 1'b0;
      r_ram_input    <= '0;
      r_pop_data     <= '0;
      r_pop_valid    <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_push_go) begin
            r_ram_input    <= io_bus.push_data;
            r_row_select   <= onehot(r_wr_ptr);
            r_write_enable <= 1'b1;
          end else if (w_pop_go) begin
            r_row_select   <= onehot(r_rd_ptr);
          end
        end
        S_WRITE: begin
          r_write_enable <= 1'b0;
          r_row_select   <= '0;
          r_wr_ptr       <= r_wr_ptr + 1'b1;
          r_count        <= r_count + 1'b1;
          r_last_write   <= 1'b1;
        end
        S_READ: begin
          r_pop_data   <= io_bus.ram_output;
          r_pop_valid  <= 1'b1;
          r_row_select <= '0;
          r_rd_ptr     <= r_rd_ptr + 1'b1;
          r_count      <= r_count - 1'b1;
          r_last_write <= 1'b0;
        end
        default: begin
          r_write_enable <= 1'b0;
          r_row_select   <= '0;
        end
      endcase
    end
  end

  assign io_bus.push_ready   = w_push_ready;
  assign io_bus.pop_ready    = w_pop_ready;
  assign io_bus.pop_data     = r_pop_data;
  assign io_bus.pop_valid    = r_pop_valid;
  assign io_bus.full         = w_full;
  assign io_bus.empty        = w_empty;
  assign io_bus.count        = r_count;
  assign io_bus.row_select   = r_row_select;
  assign io_bus.write_enable = r_write_enable;
  assign io_bus.ram_input    = r_ram_input;
endmodule

// File: tb/tb_fifo_ram32x8_controller.sv
// Scoreboard bench for the 32x8 RAM FIFO controller, with a behavioural RAM model.
module tb_fifo_ram32x8_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [32];

  fifo_ram32x8_controller_if #(.WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32)) bus ();

  fifo_ram32x8_controller #(.WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM model: latch-style write on strobe, combinational read through the selected row.
  always @(posedge clk) begin
    if (bus.write_enable)
      for (int k = 0; k < 32; k++) if (bus.row_select[k]) mem[k] <= bus.ram_input;
  end

  always_comb begin
    bus.ram_output = 8'h00;
    for (int k = 0; k < 32; k++) if (bus.row_select[k]) bus.ram_output = mem[k];
  end

  // Output side of the scoreboard plus the strobe/select invariant.
  always @(negedge clk) begin
    if (!rst && bus.pop_valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got data %h, no word expected", bus.pop_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.pop_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", bus.pop_data, e);
        end
      end
    end
    if (!rst && bus.write_enable) begin
      checks++;
      if (!$onehot(bus.row_select)) begin
        errors++;
        $display("FAIL we_onehot: row_select %h not one-hot while writing", bus.row_select);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_op(input logic [7:0] d, input logic exp_acc, output logic rdy,
                         output logic we, output logic [31:0] row, output logic [7:0] rin);
    bus.push = 1'b1; bus.push_data = d;
    #1 rdy = bus.push_ready;
    if (exp_acc) exp_q.push_back(d);
    @(posedge clk); #1;
    bus.push = 1'b0;
    we = bus.write_enable; row = bus.row_select; rin = bus.ram_input;
    if (rdy) begin @(posedge clk); #1; end
  endtask

  task automatic pop_op(output logic rdy, output logic we, output logic [31:0] row);
    bus.pop = 1'b1;
    #1 rdy = bus.pop_ready;
    @(posedge clk); #1;
    bus.pop = 1'b0;
    we = bus.write_enable; row = bus.row_select;
    if (rdy) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if (bus.row_select !== 32'h0) begin errors++; $display("FAIL reset_row: got %h expected 0", bus.row_select); end
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.write_enable); end
    checks++; if (bus.pop_valid !== 1'b0 || bus.pop_data !== 8'h00) begin
      errors++; $display("FAIL reset_pop: got valid %b data %h expected 0/00", bus.pop_valid, bus.pop_data); end
    checks++; if (bus.ram_input !== 8'h00) begin errors++; $display("FAIL reset_ram_input: got %h expected 00", bus.ram_input); end
  endtask

  task automatic test_single();
    logic rdy, we; logic [31:0] row; logic [7:0] rin;
    push_op(8'hA5, 1'b1, rdy, we, row, rin);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_push_ready: got %b expected 1", rdy); end
    checks++; if (we !== 1'b1 || row !== 32'h1 || rin !== 8'hA5) begin
      errors++; $display("FAIL single_write: got we %b row %h data %h expected 1/00000001/a5", we, row, rin); end
    checks++; if (bus.count !== 6'd1 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL single_count: got count %0d empty %b expected 1/0", bus.count, bus.empty); end
    pop_op(rdy, we, row);
    checks++; if (rdy !== 1'b1 || we !== 1'b0 || row !== 32'h1) begin
      errors++; $display("FAIL single_read: got rdy %b we %b row %h expected 1/0/00000001", rdy, we, row); end
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'hA5) begin
      errors++; $display("FAIL single_pop: got valid %b data %h expected 1/a5", bus.pop_valid, bus.pop_data); end
    checks++; if (bus.count !== 6'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL single_drain: got count %0d empty %b expected 0/1", bus.count, bus.empty); end
    @(posedge clk); #1;
    checks++; if (bus.pop_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b expected 0", bus.pop_valid); end
  endtask

  task automatic test_fill_wrap();
    logic rdy, we; logic [31:0] row, erow; logic [7:0] rin;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      erow = 32'h1 << i;
      push_op(8'(i), 1'b1, rdy, we, row, rin);
      checks++; if (rdy !== 1'b1 || row !== erow || rin !== 8'(i)) begin
        errors++; $display("FAIL fill_push%0d: got rdy %b row %h data %h expected 1/%h/%h", i, rdy, row, rin, erow, 8'(i)); end
    end
    checks++; if (bus.full !== 1'b1 || bus.count !== 6'd32 || bus.push_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got full %b count %0d ready %b expected 1/32/0", bus.full, bus.count, bus.push_ready); end
    push_op(8'hEE, 1'b0, rdy, we, row, rin);
    checks++; if (rdy !== 1'b0 || we !== 1'b0 || bus.count !== 6'd32) begin
      errors++; $display("FAIL fill_overflow: got rdy %b we %b count %0d expected 0/0/32", rdy, we, bus.count); end
    for (int i = 0; i < 32; i++) begin
      erow = 32'h1 << i;
      pop_op(rdy, we, row);
      checks++; if (rdy !== 1'b1 || we !== 1'b0 || row !== erow) begin
        errors++; $display("FAIL drain_pop%0d: got rdy %b we %b row %h expected 1/0/%h", i, rdy, we, row, erow); end
    end
    checks++; if (bus.count !== 6'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL drain_empty: got count %0d empty %b expected 0/1", bus.count, bus.empty); end
    push_op(8'h99, 1'b1, rdy, we, row, rin);
    checks++; if (row !== 32'h1) begin errors++; $display("FAIL wrap_row: got %h expected 00000001", row); end
    pop_op(rdy, we, row);
    checks++; if (row !== 32'h1) begin errors++; $display("FAIL wrap_read_row: got %h expected 00000001", row); end
  endtask

  task automatic test_round_robin();
    logic rdy, we, expw; logic [31:0] row; logic [7:0] rin, d;
    for (int i = 0; i < 5; i++) push_op(8'h40 + 8'(i), 1'b1, rdy, we, row, rin);
    checks++; if (bus.count !== 6'd5) begin errors++; $display("FAIL rr_setup: got count %0d expected 5", bus.count); end
    // Last grant was a write, so the held pop wins first.
    expw = 1'b0; d = 8'h50;
    bus.push = 1'b1; bus.pop = 1'b1; bus.push_data = d;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (bus.push_ready !== expw || bus.pop_ready !== !expw) begin
        errors++; $display("FAIL rr_grant%0d: got push_ready %b pop_ready %b expected %b/%b", i, bus.push_ready, bus.pop_ready, expw, !expw); end
      if (expw) exp_q.push_back(d);
      @(posedge clk); #1;
      checks++; if (bus.write_enable !== expw || bus.push_ready !== 1'b0 || bus.pop_ready !== 1'b0) begin
        errors++; $display("FAIL rr_busy%0d: got we %b readies %b%b expected %b/00", i, bus.write_enable, bus.push_ready, bus.pop_ready, expw); end
      @(posedge clk); #1;
      checks++; if (bus.count !== (expw ? 6'd5 : 6'd4)) begin
        errors++; $display("FAIL rr_count%0d: got %0d expected %0d", i, bus.count, expw ? 5 : 4); end
      if (expw) begin d = d + 8'd1; bus.push_data = d; end
      expw = !expw;
    end
    bus.push = 1'b0; bus.pop = 1'b0;
    for (int i = 0; i < 5; i++) pop_op(rdy, we, row);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rr_drain: got empty %b expected 1", bus.empty); end
  endtask

  task automatic test_pop_empty();
    logic rdy, we; logic [31:0] row; int nv;
    @(posedge clk); #1;
    nv = n_valid;
    pop_op(rdy, we, row);
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0 || we !== 1'b0 || row !== 32'h0) begin
      errors++; $display("FAIL empty_pop: got rdy %b we %b row %h expected 0/0/0", rdy, we, row); end
    checks++; if (n_valid !== nv || bus.count !== 6'd0) begin
      errors++; $display("FAIL empty_valid: got %0d pulses count %0d expected 0 pulses count 0", n_valid - nv, bus.count); end
  endtask

  task automatic test_reset_mid_write();
    logic rdy, we; logic [31:0] row; logic [7:0] rin;
    bus.push = 1'b1; bus.push_data = 8'h77;
    @(posedge clk); #1;
    bus.push = 1'b0;
    checks++; if (bus.write_enable !== 1'b1) begin errors++; $display("FAIL midrst_setup: got we %b expected 1", bus.write_enable); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.write_enable !== 1'b0 || bus.row_select !== 32'h0) begin
      errors++; $display("FAIL midrst_async: got we %b row %h expected 0/0", bus.write_enable, bus.row_select); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.count !== 6'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL midrst_state: got count %0d empty %b expected 0/1", bus.count, bus.empty); end
    push_op(8'h3C, 1'b1, rdy, we, row, rin);
    checks++; if (rdy !== 1'b1 || row !== 32'h1) begin
      errors++; $display("FAIL midrst_row0: got rdy %b row %h expected 1/00000001", rdy, row); end
    pop_op(rdy, we, row);
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = 8'h00;
    test_reset();
    test_single();
    test_fill_wrap();
    test_round_robin();
    test_pop_empty();
    test_reset_mid_write();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d words undelivered expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
